rename_regfile: RTL



---
 rtl/rename_regfile_if.sv | 36 +++
 rtl/rename_regfile.sv | 99 +++++++++
 2 files changed

// File: rtl/rename_regfile_if.sv
// Commit, rename and operand-lookup bundle between ROB/dispatcher and the register file.
// master = ROB/dispatcher side, slave = register file.
interface rename_regfile_if #(
    parameter int DATA_W = 32,
    parameter int NAME_W = 5,
    parameter int TAG_W  = 5
);
    logic              enCom;
    logic [TAG_W-1:0]  ComTag;
    logic [DATA_W-1:0] ComData;
    logic [NAME_W-1:0] ComName;
    logic              mis;
    logic              enRename;
    logic [NAME_W-1:0] RenameName;
    logic [TAG_W-1:0]  RenameTag;
    logic [NAME_W-1:0] ReadNameO;
    logic [NAME_W-1:0] ReadNameT;
    logic [TAG_W-1:0]  ReadTagO;
    logic [TAG_W-1:0]  ReadTagT;
    logic [DATA_W-1:0] ReadDataO;
    logic [DATA_W-1:0] ReadDataT;

    modport master (
        output enCom, ComTag, ComData, ComName, mis,
        output enRename, RenameName, RenameTag,
        output ReadNameO, ReadNameT,
        input  ReadTagO, ReadTagT, ReadDataO, ReadDataT
    );

    modport slave (
        input  enCom, ComTag, ComData, ComName, mis,
        input  enRename, RenameName, RenameTag,
        input  ReadNameO, ReadNameT,
        output ReadTagO, ReadTagT, ReadDataO, ReadDataT
    );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags, commit bypass and one-cycle flush.
// Reads are combinational (0 cycles); no backpressure, every enabled op is accepted while rdy=1.
module rename_regfile #(
    parameter int               DATA_W   = 32,
    parameter int               NAME_W   = 5,
    parameter int               TAG_W    = 5,
    parameter logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    rename_regfile_if.slave   rf
);
    localparam int NREG = 1 << NAME_W;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic [DATA_W-1:0] data_q [NREG];
    logic [TAG_W-1:0]  tag_q  [NREG];
    logic [NREG-1:0]   com_sel;
    logic [NREG-1:0]   ren_sel;
    logic              byp_ok;
    rd_t               rd_o;
    rd_t               rd_t_port;

    // x0 is excluded at decode so the state loop below can treat every entry alike.
    always_comb begin
        com_sel = '0;
        ren_sel = '0;
        if (rf.enCom && rf.ComName != '0)
            com_sel[rf.ComName] = 1'b1;
        if (rf.enRename && rf.RenameName != '0)
            ren_sel[rf.RenameName] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= TAG_FREE;
            end
        end else if (rdy) begin
            for (int i = 0; i < NREG; i++) begin
                if (com_sel[i])
                    data_q[i] <= rf.ComData;
                // Flush beats rename; rename beats the commit's tag release.
                if (rf.mis)
                    tag_q[i] <= TAG_FREE;
                else if (ren_sel[i])
                    tag_q[i] <= rf.RenameTag;
                else if (com_sel[i] && tag_q[i] == rf.ComTag)
                    tag_q[i] <= TAG_FREE;
            end
        end
    end

    assign byp_ok = rdy && rf.enCom && !rf.mis;

    function automatic rd_t lookup(
        input logic [NAME_W-1:0] n,
        input logic [TAG_W-1:0]  t,
        input logic [DATA_W-1:0] d,
        input logic              byp,
        input logic [DATA_W-1:0] bd
    );
        rd_t r;
        if (n == '0) begin
            r.tag  = TAG_FREE;
            r.data = '0;
        end else if (byp) begin
            r.tag  = TAG_FREE;
            r.data = bd;
        end else if (t == TAG_FREE) begin
            r.tag  = TAG_FREE;
            r.data = d;
        end else begin
            r.tag  = t;
            r.data = '0;
        end
        return r;
    endfunction

    always_comb begin
        rd_o = lookup(rf.ReadNameO, tag_q[rf.ReadNameO], data_q[rf.ReadNameO],
                      byp_ok && rf.ComName == rf.ReadNameO && tag_q[rf.ReadNameO] == rf.ComTag,
                      rf.ComData);
        rd_t_port = lookup(rf.ReadNameT, tag_q[rf.ReadNameT], data_q[rf.ReadNameT],
                           byp_ok && rf.ComName == rf.ReadNameT && tag_q[rf.ReadNameT] == rf.ComTag,
                           rf.ComData);
    end

    assign rf.ReadTagO  = rd_o.tag;
    assign rf.ReadDataO = rd_o.data;
    assign rf.ReadTagT  = rd_t_port.tag;
    assign rf.ReadDataT = rd_t_port.data;
endmodule
